// File: rtl/color_pkg.sv
// Shared types for the dominant-colour path: the 2-bit colour code that the
// HEX display decoder consumes, and the frame-tracking FSM states.
package color_pkg;

  // Colour code carried on the main interface. COLOR_NONE blanks the display.
  typedef enum logic [1:0] {
    COLOR_RED   = 2'd0,
    COLOR_GREEN = 2'd1,
    COLOR_BLUE  = 2'd2,
    COLOR_NONE  = 2'd3
  } color_t;

  // Frame tracking: waiting for sop, counting votes, emitting the decision.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_classifier.sv
// Combinational per-pixel vote: dark pixels vote none, otherwise the largest
// channel wins with ties resolved red > green > blue.
module pixel_classifier
  import color_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int DARK_MIN = 32
) (
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output color_t           color
);

  // One extra bit so a threshold of 2^PIX_W is still representable.
  localparam logic [PIX_W:0] DARK_LIM = DARK_MIN[PIX_W:0];

  logic [PIX_W-1:0] max_ch;

  // Brightest channel, then the ordered vote.
  always_comb begin
    max_ch = r;
    if (g > max_ch) max_ch = g;
    if (b > max_ch) max_ch = b;

    if ({1'b0, max_ch} < DARK_LIM) begin
      color = COLOR_NONE;
    end else if (r >= g && r >= b) begin
      color = COLOR_RED;
    end else if (g >= b) begin
      color = COLOR_GREEN;
    end else begin
      color = COLOR_BLUE;
    end
  end

endmodule

// File: rtl/dominant_color_detector.sv
// Streaming dominant-colour detector. Pixels are voted, counted per class over
// a frame, and at end of frame the winning colour is presented on main with a
// one-cycle main_valid pulse, three edges after the eop pixel is sampled.
//
// Handshake: in_valid qualifies in_sop/in_eop/in_r/in_g/in_b; there is no
// ready, every valid pixel is consumed on the edge it is sampled. main_valid
// is a single-cycle strobe with no ready; main holds its value between strobes.
module dominant_color_detector
  import color_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CNT_W    = 20,
  parameter int DARK_MIN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output color_t           main,
  output logic             main_valid,
  output state_t           dbg_state
);

  color_t           vote;
  logic             s1_valid;
  logic             s1_sop;
  logic             s1_eop;
  color_t           s1_color;
  logic [3:0]       s1_hit;

  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [CNT_W-1:0] snap_q [4];

  state_t           state_q;
  state_t           state_d;
  logic             start;
  logic             count;
  logic             frame_end;

  color_t           win;
  color_t           win_q;
  logic             win_v;

  pixel_classifier #(
    .PIX_W    (PIX_W),
    .DARK_MIN (DARK_MIN)
  ) u_classifier (
    .r     (in_r),
    .g     (in_g),
    .b     (in_b),
    .color (vote)
  );

  assign dbg_state = state_q;

  // Stage 1: register the vote together with its framing flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_color <= COLOR_NONE;
    end else begin
      s1_valid <= in_valid;
      s1_sop   <= in_sop;
      s1_eop   <= in_eop;
      s1_color <= vote;
    end
  end

  // Counter update and next state. A valid sop always (re)starts a frame, even
  // while the previous frame is in DECIDE, so back-to-back frames lose nothing.
  always_comb begin
    s1_hit    = 4'd1 << s1_color;
    start     = s1_valid && s1_sop;
    count     = s1_valid && !s1_sop && (state_q == ST_ACCUM);
    frame_end = (start || count) && s1_eop;
    state_d   = state_q;

    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (start) begin
        cnt_d[i] = s1_hit[i] ? CNT_W'(1) : '0;
      end else if (count && s1_hit[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (start || count) begin
      state_d = s1_eop ? ST_DECIDE : ST_ACCUM;
    end else if (state_q == ST_DECIDE) begin
      state_d = ST_IDLE;
    end
  end

  // Stage 2: counters, FSM state, and the end-of-frame snapshot that DECIDE
  // compares while the counters are free to start the next frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (frame_end) snap_q[i] <= cnt_d[i];
      end
    end
  end

  // Decision comparator on the snapshot; the none count never wins, it only
  // matters in that a frame with no coloured votes is reported blank.
  always_comb begin
    if ((snap_q[COLOR_RED] | snap_q[COLOR_GREEN] | snap_q[COLOR_BLUE]) == '0) begin
      win = COLOR_NONE;
    end else if (snap_q[COLOR_RED] >= snap_q[COLOR_GREEN] &&
                 snap_q[COLOR_RED] >= snap_q[COLOR_BLUE]) begin
      win = COLOR_RED;
    end else if (snap_q[COLOR_GREEN] >= snap_q[COLOR_BLUE]) begin
      win = COLOR_GREEN;
    end else begin
      win = COLOR_BLUE;
    end
  end

  // Stage 3a: capture the decision during the DECIDE cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_q <= COLOR_NONE;
      win_v <= 1'b0;
    end else begin
      win_v <= (state_q == ST_DECIDE);
      if (state_q == ST_DECIDE) win_q <= win;
    end
  end

  // Stage 3b: output register; main holds until the next decision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main       <= COLOR_NONE;
      main_valid <= 1'b0;
    end else begin
      main_valid <= win_v;
      if (win_v) main <= win_q;
    end
  end

endmodule

// File: tb/tb_dominant_color_detector.sv
// Bench for dominant_color_detector: one-pixel frames from a vote table, then
// hand-written multi-pixel sequences; a pulse monitor checks every main_valid
// against an expected queue of {colour, cycle}.
module tb_dominant_color_detector;
  import color_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_g = '0;
  logic [7:0] in_b = '0;

  logic [1:0] main;
  logic       main_valid;
  state_t     dbg_state;
  logic [1:0] main3;
  logic       main_valid3;
  state_t     dbg_state3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[14];

  dominant_color_detector #(.PIX_W(8), .CNT_W(20), .DARK_MIN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .main       (main),
    .main_valid (main_valid),
    .dbg_state  (dbg_state)
  );

  dominant_color_detector #(.PIX_W(8), .CNT_W(3), .DARK_MIN(32)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .main       (main3),
    .main_valid (main_valid3),
    .dbg_state  (dbg_state3)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: one pixel presented for one edge, inputs return to idle after.
  task automatic px(input logic sop, input logic eop, input logic [7:0] r,
                    input logic [7:0] g, input logic [7:0] b);
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_r     = r;
    in_g     = g;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after the eop pixel's edge: pulse due three edges later.
  task automatic expect_main(input logic [1:0] c);
    exp_q.push_back(c);
    exp_cyc_q.push_back(cyc + 3);
  endtask

  // Scoreboard: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (main_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: main=%0d at cycle %0d, expected no pulse", main, cyc);
      end else begin
        check("pulse_cycle", cyc, exp_cyc_q.pop_front());
        check("pulse_main", {30'd0, main}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    vecs[0]  = '{8'd0,   8'd0,   8'd255, 2'd2};
    vecs[1]  = '{8'd5,   8'd5,   8'd5,   2'd3};
    vecs[2]  = '{8'd31,  8'd0,   8'd0,   2'd3};
    vecs[3]  = '{8'd32,  8'd0,   8'd0,   2'd0};
    vecs[4]  = '{8'd0,   8'd32,  8'd0,   2'd1};
    vecs[5]  = '{8'd0,   8'd0,   8'd32,  2'd2};
    vecs[6]  = '{8'd100, 8'd100, 8'd50,  2'd0};
    vecs[7]  = '{8'd50,  8'd100, 8'd100, 2'd1};
    vecs[8]  = '{8'd100, 8'd50,  8'd100, 2'd0};
    vecs[9]  = '{8'd40,  8'd40,  8'd40,  2'd0};
    vecs[10] = '{8'd10,  8'd20,  8'd30,  2'd3};
    vecs[11] = '{8'd10,  8'd20,  8'd200, 2'd2};
    vecs[12] = '{8'd255, 8'd255, 8'd255, 2'd0};
    vecs[13] = '{8'd0,   8'd200, 8'd199, 2'd1};

    // Reset with idle inputs, then hold
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    for (int i = 0; i < 10; i++) begin
      check("reset_main", {30'd0, main}, 32'd3);
      check("reset_valid", {31'd0, main_valid}, 32'd0);
      bubble(1);
    end

    // Vote table as one-pixel frames (sop and eop on the same pixel)
    for (int i = 0; i < 14; i++) begin
      px(1'b1, 1'b1, vecs[i].r, vecs[i].g, vecs[i].b);
      expect_main(vecs[i].exp);
      bubble(4);
      check("vec_main", {30'd0, main}, {30'd0, vecs[i].exp});
    end

    // 3 red + 1 green, red wins; main holds afterwards
    px(1'b1, 1'b0, 8'd200, 8'd10, 8'd10);
    px(1'b0, 1'b0, 8'd200, 8'd10, 8'd10);
    px(1'b0, 1'b0, 8'd200, 8'd10, 8'd10);
    px(1'b0, 1'b1, 8'd10, 8'd200, 8'd10);
    expect_main(2'd0);
    bubble(10);
    check("hold_main", {30'd0, main}, 32'd0);
    check("hold_valid", {31'd0, main_valid}, 32'd0);

    // Blue frame first so the next red decision is a visible change
    px(1'b1, 1'b1, 8'd0, 8'd0, 8'd90);
    expect_main(2'd2);
    bubble(4);

    // R2 G2 B2 via tie pixels: red wins the tie
    px(1'b1, 1'b0, 8'd0, 8'd90, 8'd0);
    px(1'b0, 1'b0, 8'd0, 8'd90, 8'd0);
    px(1'b0, 1'b0, 8'd0, 8'd0, 8'd90);
    px(1'b0, 1'b0, 8'd0, 8'd0, 8'd90);
    px(1'b0, 1'b0, 8'd100, 8'd100, 8'd50);
    px(1'b0, 1'b1, 8'd40, 8'd40, 8'd40);
    expect_main(2'd0);
    bubble(5);

    // All-dark frame
    for (int i = 0; i < 4; i++) px(i == 0, i == 3, 8'd5, 8'd5, 8'd5);
    expect_main(2'd3);
    bubble(5);

    // Back-to-back: blue frame, then green frame with bubbles starting next cycle
    px(1'b1, 1'b0, 8'd0, 8'd0, 8'd90);
    px(1'b0, 1'b0, 8'd0, 8'd0, 8'd90);
    px(1'b0, 1'b1, 8'd0, 8'd0, 8'd90);
    expect_main(2'd2);
    px(1'b1, 1'b0, 8'd0, 8'd90, 8'd0);
    bubble(1);
    px(1'b0, 1'b0, 8'd0, 8'd90, 8'd0);
    bubble(1);
    px(1'b0, 1'b1, 8'd0, 8'd90, 8'd0);
    expect_main(2'd1);
    bubble(6);
    check("b2b_main", {30'd0, main}, 32'd1);

    // Mid-frame restart: the three red pixels before the second sop are discarded
    px(1'b1, 1'b0, 8'd200, 8'd0, 8'd0);
    px(1'b0, 1'b0, 8'd200, 8'd0, 8'd0);
    px(1'b0, 1'b0, 8'd200, 8'd0, 8'd0);
    px(1'b1, 1'b0, 8'd0, 8'd0, 8'd200);
    px(1'b0, 1'b0, 8'd0, 8'd0, 8'd200);
    px(1'b0, 1'b1, 8'd0, 200, 8'd0);
    expect_main(2'd2);
    bubble(6);
    check("restart_main", {30'd0, main}, 32'd2);

    // Reset mid-frame: frame aborted, trailing eop ignored, display blanked
    px(1'b1, 1'b0, 8'd0, 8'd200, 8'd0);
    px(1'b0, 1'b0, 8'd0, 8'd200, 8'd0);
    reset_n = 1'b0;
    bubble(2);
    reset_n = 1'b1;
    px(1'b0, 1'b1, 8'd0, 8'd200, 8'd0);
    bubble(6);
    check("abort_main", {30'd0, main}, 32'd3);
    check("abort_valid", {31'd0, main_valid}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // Saturation: 10 red + 9 green; narrow counters both stick at 7, red wins tie
    for (int i = 0; i < 19; i++) begin
      if (i < 10) px(i == 0, 1'b0, 8'd200, 8'd0, 8'd0);
      else        px(1'b0, i == 18, 8'd0, 8'd200, 8'd0);
    end
    expect_main(2'd0);
    bubble(6);
    check("sat_wide_a", {30'd0, main}, 32'd0);
    check("sat_narrow_a", {30'd0, main3}, 32'd0);

    // 9 red + 10 green: wide counters pick green, saturated ones tie to red
    for (int i = 0; i < 19; i++) begin
      if (i < 9) px(i == 0, 1'b0, 8'd200, 8'd0, 8'd0);
      else       px(1'b0, i == 18, 8'd0, 8'd200, 8'd0);
    end
    expect_main(2'd1);
    bubble(6);
    check("sat_wide_b", {30'd0, main}, 32'd1);
    check("sat_narrow_b", {30'd0, main3}, 32'd0);

    bubble(10);
    check("pulses_outstanding", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
